// File: rtl/video_timing_monitor.sv
// Passive checker for a VGA-style timing stream: locks onto hsync/vsync, flags
// timing and blanking violations, and signs each completed frame's visible pixels.
module video_timing_monitor #(
  parameter int H_SYNC      = 48,
  parameter int H_BACK      = 24,
  parameter int H_VISIBLE   = 320,
  parameter int H_TOTAL     = 400,
  parameter int V_SYNC_BACK = 35,
  parameter int V_VISIBLE   = 480,
  parameter int V_TOTAL     = 525
) (
  input  logic        clk_12_5875,
  input  logic        rst,
  input  logic [1:0]  r,
  input  logic [1:0]  g,
  input  logic [1:0]  b,
  input  logic        hsync,
  input  logic        vsync,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic        blank_err,
  output logic        frame_done,
  output logic [15:0] frame_sig,
  output logic [15:0] frame_count
);

  localparam logic [9:0] CNT_MAX  = '1;
  localparam logic [9:0] H_LO     = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_HI     = 10'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [9:0] V_LO     = 10'(V_SYNC_BACK);
  localparam logic [9:0] V_HI     = 10'(V_SYNC_BACK + V_VISIBLE);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);

  logic [5:0]  rgb_s;
  logic        hs_s, vs_s, hs_p, vs_p;
  logic [9:0]  h_cnt, v_cnt;
  logic        h_locked, v_locked;
  logic [15:0] acc;

  logic        h_edge, h_rise, v_edge, visible;
  logic [9:0]  h_cur, v_cur;
  logic [15:0] acc_upd;
  logic        h_err_n, v_err_n, blank_err_n, h_locked_n, v_locked_n;

  // Sync history resets high so a sync already low right after reset is seen as an edge.
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      rgb_s <= '0;
      hs_s  <= 1'b1;
      vs_s  <= 1'b1;
      hs_p  <= 1'b1;
      vs_p  <= 1'b1;
    end else begin
      rgb_s <= {r, g, b};
      hs_s  <= hsync;
      vs_s  <= vsync;
      hs_p  <= hs_s;
      vs_p  <= vs_s;
    end
  end

  always_comb begin
    h_edge  = hs_p & ~hs_s;
    h_rise  = ~hs_p & hs_s;
    v_edge  = vs_p & ~vs_s;

    h_cur = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 10'd1;
    if (h_edge) h_cur = '0;

    v_cur = v_cnt;
    if (h_edge && v_cnt != CNT_MAX) v_cur = v_cnt + 10'd1;
    if (v_edge) v_cur = '0;

    visible = h_locked & v_locked &
              (h_cur >= H_LO) & (h_cur < H_HI) &
              (v_cur >= V_LO) & (v_cur < V_HI);

    acc_upd = acc;
    if (visible) acc_upd = {acc[14:0], acc[15]} ^ {10'b0, rgb_s};

    // h_cnt/v_cnt still hold the previous sample's values here, which is what the edge checks need.
    h_err_n = h_err |
              (h_edge & h_locked & (h_cnt != H_LAST)) |
              (h_rise & h_locked & (h_cur != H_SYNC_W));
    v_err_n = v_err |
              (v_edge & ~h_edge) |
              (v_edge & v_locked & (v_cnt != V_LAST));
    blank_err_n = blank_err | (~visible & h_locked & v_locked & (rgb_s != 6'd0));

    h_locked_n = h_locked | h_edge;
    v_locked_n = v_locked | v_edge;
  end

  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_locked    <= 1'b0;
      v_locked    <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      blank_err   <= 1'b0;
      acc         <= '0;
      frame_sig   <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
      locked      <= 1'b0;
    end else begin
      h_cnt      <= h_cur;
      v_cnt      <= v_cur;
      h_locked   <= h_locked_n;
      v_locked   <= v_locked_n;
      h_err      <= h_err_n;
      v_err      <= v_err_n;
      blank_err  <= blank_err_n;
      acc        <= v_edge ? 16'd0 : acc_upd;
      frame_done <= v_edge & v_locked;
      // The first V-edge after reset only opens a frame; later edges close one.
      if (v_edge && v_locked) begin
        frame_sig   <= acc_upd;
        frame_count <= frame_count + 16'd1;
      end
      locked <= h_locked_n & v_locked_n & ~h_err_n & ~v_err_n & ~blank_err_n;
    end
  end

endmodule
